// File: rtl/mc_seq_ctrl_pkg.sv
// Shared encodings for the multi-cycle sequencer: state codes, instruction classes,
// and the MIPS opcode/funct values the class decoder recognises.
package mc_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    ClsAlu     = 3'd0,
    ClsLoad    = 3'd1,
    ClsStore   = 3'd2,
    ClsBranch  = 3'd3,
    ClsJalr    = 3'd4,
    ClsJ       = 3'd5,
    ClsJal     = 3'd6,
    ClsIllegal = 3'd7
  } cls_e;

  localparam logic [5:0] OpRtype  = 6'b000000;
  localparam logic [5:0] OpRegimm = 6'b000001;
  localparam logic [5:0] OpJ      = 6'b000010;
  localparam logic [5:0] OpJal    = 6'b000011;
  localparam logic [5:0] OpBeq    = 6'b000100;
  localparam logic [5:0] OpBne    = 6'b000101;
  localparam logic [5:0] OpBlez   = 6'b000110;
  localparam logic [5:0] OpBgtz   = 6'b000111;
  localparam logic [5:0] OpAddi   = 6'b001000;
  localparam logic [5:0] OpAddiu  = 6'b001001;
  localparam logic [5:0] OpSlti   = 6'b001010;
  localparam logic [5:0] OpSltiu  = 6'b001011;
  localparam logic [5:0] OpAndi   = 6'b001100;
  localparam logic [5:0] OpOri    = 6'b001101;
  localparam logic [5:0] OpXori   = 6'b001110;
  localparam logic [5:0] OpLui    = 6'b001111;
  localparam logic [5:0] OpLb     = 6'b100000;
  localparam logic [5:0] OpLh     = 6'b100001;
  localparam logic [5:0] OpLw     = 6'b100011;
  localparam logic [5:0] OpLbu    = 6'b100100;
  localparam logic [5:0] OpLhu    = 6'b100101;
  localparam logic [5:0] OpSb     = 6'b101000;
  localparam logic [5:0] OpSh     = 6'b101001;
  localparam logic [5:0] OpSw     = 6'b101011;

  localparam logic [5:0] FnSll  = 6'b000000;
  localparam logic [5:0] FnSrl  = 6'b000010;
  localparam logic [5:0] FnSra  = 6'b000011;
  localparam logic [5:0] FnSllv = 6'b000100;
  localparam logic [5:0] FnSrlv = 6'b000110;
  localparam logic [5:0] FnSrav = 6'b000111;
  localparam logic [5:0] FnJr   = 6'b001000;
  localparam logic [5:0] FnJalr = 6'b001001;
  localparam logic [5:0] FnAdd  = 6'b100000;
  localparam logic [5:0] FnAddu = 6'b100001;
  localparam logic [5:0] FnSub  = 6'b100010;
  localparam logic [5:0] FnSubu = 6'b100011;
  localparam logic [5:0] FnAnd  = 6'b100100;
  localparam logic [5:0] FnOr   = 6'b100101;
  localparam logic [5:0] FnXor  = 6'b100110;
  localparam logic [5:0] FnNor  = 6'b100111;
  localparam logic [5:0] FnSlt  = 6'b101010;
  localparam logic [5:0] FnSltu = 6'b101011;

endpackage

// File: rtl/mc_op_class.sv
// Combinational op/funct to instruction-class decoder; shared with the hazard logic.
module mc_op_class
  import mc_seq_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [2:0] cls
);

  always_comb begin
    cls = ClsIllegal;
    case (op)
      OpRtype: begin
        case (funct)
          FnJr:   cls = ClsBranch;
          FnJalr: cls = ClsJalr;
          FnSll, FnSrl, FnSra, FnSllv, FnSrlv, FnSrav,
          FnAdd, FnAddu, FnSub, FnSubu, FnAnd, FnOr, FnXor, FnNor,
          FnSlt, FnSltu: cls = ClsAlu;
          default: cls = ClsIllegal;
        endcase
      end
      OpAddi, OpAddiu, OpSlti, OpSltiu, OpAndi, OpOri, OpXori, OpLui: cls = ClsAlu;
      OpLb, OpLh, OpLw, OpLbu, OpLhu:                                 cls = ClsLoad;
      OpSb, OpSh, OpSw:                                               cls = ClsStore;
      OpBeq, OpBne, OpBlez, OpBgtz, OpRegimm:                         cls = ClsBranch;
      OpJ:                                                            cls = ClsJ;
      OpJal:                                                          cls = ClsJal;
      default:                                                        cls = ClsIllegal;
    endcase
  end

endmodule

// File: rtl/mc_seq_ctrl.sv
// Multi-cycle instruction sequencer: steps FETCH/DECODE/EXEC/MEM/WB and times every
// state-changing write strobe; halts on illegal instructions and counts retirements.
module mc_seq_ctrl
  import mc_seq_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        run,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic        imem_rdy,
  input  logic        dmem_rdy,
  output logic        imem_req,
  output logic        ir_we,
  output logic        pc_we,
  output logic        rf_we,
  output logic        dm_re,
  output logic        dm_we,
  output logic [2:0]  state,
  output logic        halted,
  output logic        instr_done,
  output logic [31:0] retired
);

  state_e      state_q, state_d;
  cls_e        cls_q, cls_d;
  logic [31:0] retired_q, retired_d;
  logic [2:0]  dec_cls;

  mc_op_class u_op_class (
    .op    (op),
    .funct (funct),
    .cls   (dec_cls)
  );

  always_comb begin
    state_d  = state_q;
    cls_d    = cls_q;
    imem_req = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    rf_we    = 1'b0;
    dm_re    = 1'b0;
    dm_we    = 1'b0;
    halted   = 1'b0;
    unique case (state_q)
      StFetch: begin
        imem_req = run;
        if (run && imem_rdy) begin
          ir_we   = 1'b1;
          state_d = StDecode;
        end
      end
      StDecode: begin
        // Class is used live here and latched for the remaining states.
        cls_d = cls_e'(dec_cls);
        case (cls_e'(dec_cls))
          ClsJ: begin
            pc_we   = 1'b1;
            state_d = StFetch;
          end
          ClsJal: begin
            pc_we   = 1'b1;
            rf_we   = 1'b1;
            state_d = StFetch;
          end
          ClsIllegal: state_d = StHalt;
          default:    state_d = StExec;
        endcase
      end
      StExec: begin
        case (cls_q)
          ClsBranch: begin
            pc_we   = 1'b1;
            state_d = StFetch;
          end
          ClsJalr: begin
            pc_we   = 1'b1;
            rf_we   = 1'b1;
            state_d = StFetch;
          end
          ClsLoad, ClsStore: state_d = StMem;
          ClsAlu:            state_d = StWb;
          default:           state_d = StFetch;
        endcase
      end
      StMem: begin
        case (cls_q)
          ClsLoad: begin
            dm_re = 1'b1;
            if (dmem_rdy) state_d = StWb;
          end
          ClsStore: begin
            dm_we = 1'b1;
            if (dmem_rdy) begin
              pc_we   = 1'b1;
              state_d = StFetch;
            end
          end
          default: state_d = StFetch;
        endcase
      end
      StWb: begin
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        state_d = StFetch;
      end
      StHalt: halted = 1'b1;
      default: state_d = StFetch;
    endcase
  end

  assign instr_done = pc_we;
  assign retired_d  = retired_q + {31'd0, pc_we};

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= StFetch;
      cls_q     <= ClsAlu;
      retired_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      retired_q <= retired_d;
    end
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_mc_seq_ctrl.sv
// Directed bench for mc_seq_ctrl: inputs change on the falling edge, outputs are checked
// 1 ns later against hand-computed per-cycle state and strobe vectors.
module tb_mc_seq_ctrl;

  logic        clk;
  logic        rstn;
  logic        run;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        imem_rdy;
  logic        dmem_rdy;
  logic        imem_req;
  logic        ir_we;
  logic        pc_we;
  logic        rf_we;
  logic        dm_re;
  logic        dm_we;
  logic [2:0]  state;
  logic        halted;
  logic        instr_done;
  logic [31:0] retired;
  logic [7:0]  strb;

  int n_cmp = 0;
  int n_err = 0;

  mc_seq_ctrl dut (
    .clk        (clk),
    .rstn       (rstn),
    .run        (run),
    .op         (op),
    .funct      (funct),
    .imem_rdy   (imem_rdy),
    .dmem_rdy   (dmem_rdy),
    .imem_req   (imem_req),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .rf_we      (rf_we),
    .dm_re      (dm_re),
    .dm_we      (dm_we),
    .state      (state),
    .halted     (halted),
    .instr_done (instr_done),
    .retired    (retired)
  );

  // {imem_req, ir_we, pc_we, rf_we, dm_re, dm_we, halted, instr_done}
  assign strb = {imem_req, ir_we, pc_we, rf_we, dm_re, dm_we, halted, instr_done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Check the current cycle, then advance to the next falling edge.
  task automatic cyc(input string tag, input logic [2:0] est, input logic [7:0] estb);
    #1;
    check_val({tag, ".state"}, {29'd0, state}, {29'd0, est});
    check_val({tag, ".strb"}, {24'd0, strb}, {24'd0, estb});
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn     = 1'b0;
    run      = 1'b1;
    imem_rdy = 1'b0;
    dmem_rdy = 1'b0;
    op       = 6'd0;
    funct    = 6'd0;
    @(negedge clk);
    @(negedge clk);

    rstn = 1'b1;
    check_val("rst.retired", retired, 32'd0);
    cyc("rst", 3'd0, 8'b1000_0000);

    // ADDU: retires on cycle 4 via WB
    op = 6'b000000; funct = 6'b100001; imem_rdy = 1'b1; dmem_rdy = 1'b1;
    cyc("addu.c1", 3'd0, 8'b1100_0000);
    cyc("addu.c2", 3'd1, 8'b0000_0000);
    cyc("addu.c3", 3'd2, 8'b0000_0000);
    cyc("addu.c4", 3'd4, 8'b0011_0001);
    run = 1'b0;
    check_val("addu.retired", retired, 32'd1);
    cyc("addu.idle", 3'd0, 8'b0000_0000);

    // LW with dmem_rdy low for 3 MEM cycles
    run = 1'b1; op = 6'b100011; dmem_rdy = 1'b0;
    cyc("lw.c1", 3'd0, 8'b1100_0000);
    cyc("lw.c2", 3'd1, 8'b0000_0000);
    cyc("lw.c3", 3'd2, 8'b0000_0000);
    cyc("lw.c4", 3'd3, 8'b0000_1000);
    cyc("lw.c5", 3'd3, 8'b0000_1000);
    cyc("lw.c6", 3'd3, 8'b0000_1000);
    dmem_rdy = 1'b1;
    cyc("lw.c7", 3'd3, 8'b0000_1000);
    cyc("lw.c8", 3'd4, 8'b0011_0001);
    run = 1'b0;
    check_val("lw.retired", retired, 32'd2);
    cyc("lw.idle", 3'd0, 8'b0000_0000);

    // BEQ, JAL, JR back-to-back: pc_we on cycles 3, 5, 8
    run = 1'b1; op = 6'b000100;
    cyc("beq.c1", 3'd0, 8'b1100_0000);
    cyc("beq.c2", 3'd1, 8'b0000_0000);
    cyc("beq.c3", 3'd2, 8'b0010_0001);
    op = 6'b000011;
    cyc("jal.c4", 3'd0, 8'b1100_0000);
    cyc("jal.c5", 3'd1, 8'b0011_0001);
    op = 6'b000000; funct = 6'b001000;
    cyc("jr.c6", 3'd0, 8'b1100_0000);
    cyc("jr.c7", 3'd1, 8'b0000_0000);
    cyc("jr.c8", 3'd2, 8'b0010_0001);
    run = 1'b0;
    check_val("br.retired", retired, 32'd5);
    cyc("br.idle", 3'd0, 8'b0000_0000);

    // SW with dmem_rdy high: dm_we and pc_we together on cycle 4
    run = 1'b1; op = 6'b101011; dmem_rdy = 1'b1;
    cyc("sw.c1", 3'd0, 8'b1100_0000);
    cyc("sw.c2", 3'd1, 8'b0000_0000);
    cyc("sw.c3", 3'd2, 8'b0000_0000);
    cyc("sw.c4", 3'd3, 8'b0010_0101);
    run = 1'b0;
    check_val("sw.retired", retired, 32'd6);
    cyc("sw.idle", 3'd0, 8'b0000_0000);

    // Illegal opcode halts until reset
    run = 1'b1; op = 6'b111111;
    cyc("ill.c1", 3'd0, 8'b1100_0000);
    cyc("ill.c2", 3'd1, 8'b0000_0000);
    for (int i = 0; i < 20; i++) begin
      cyc("ill.halt", 3'd5, 8'b0000_0010);
    end
    check_val("ill.retired", retired, 32'd6);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1; run = 1'b0;
    check_val("ill.rst.retired", retired, 32'd0);
    cyc("ill.rst", 3'd0, 8'b0000_0000);

    // SW stalled in MEM, reset on second MEM cycle aborts without retiring
    run = 1'b1; imem_rdy = 1'b1; op = 6'b101011; dmem_rdy = 1'b0;
    cyc("abort.c1", 3'd0, 8'b1100_0000);
    cyc("abort.c2", 3'd1, 8'b0000_0000);
    cyc("abort.c3", 3'd2, 8'b0000_0000);
    cyc("abort.c4", 3'd3, 8'b0000_0100);
    rstn = 1'b0;
    cyc("abort.c5", 3'd3, 8'b0000_0100);
    rstn = 1'b1; imem_rdy = 1'b0;
    check_val("abort.retired", retired, 32'd0);
    cyc("abort.after", 3'd0, 8'b1000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
